// File: rtl/ps2_lcd_pkg.sv
// Shared types and constants for the PS/2 keyboard to LCD line editor.
// Holds FSM states, key classes, LCD command words and small helpers.
package ps2_lcd_pkg;

    typedef enum logic [3:0] {
        S_INIT          = 4'd0,
        S_INIT_WAIT     = 4'd1,
        S_IDLE          = 4'd2,
        S_SET_LINE      = 4'd3,
        S_SET_LINE_WAIT = 4'd4,
        S_ROM_WAIT      = 4'd5,
        S_ISSUE_CHAR    = 4'd6,
        S_CHAR_WAIT     = 4'd7,
        S_FLUSH_DONE    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        K_SHIFT_L = 3'd0,
        K_SHIFT_R = 3'd1,
        K_BKSP    = 3'd2,
        K_ENTER   = 3'd3,
        K_PRINT   = 3'd4
    } key_class_t;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_BKSP   = 8'h66;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_SPACE  = 8'h29;

    localparam logic [8:0] LCD_FUNC_SET = 9'h038;
    localparam logic [8:0] LCD_DISP_ON  = 9'h00C;
    localparam logic [8:0] LCD_CLEAR    = 9'h001;
    localparam logic [8:0] LCD_ENTRY    = 9'h006;

    function automatic logic [8:0] init_cmd(input logic [1:0] step);
        logic [8:0] cmd;
        case (step)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_CLEAR;
            default: cmd = LCD_ENTRY;
        endcase
        return cmd;
    endfunction

    // DDRAM address command for the start of LCD line 0 or 1
    function automatic logic [8:0] line_instr(input logic sel);
        return {2'b01, sel, 6'h00};
    endfunction

endpackage

// File: rtl/ps2_lcd_line_editor_key_filter.sv
// Turns the PS/2 controller's level-style ready into single make-code events,
// classifies them, and flags events that arrive while the editor cannot take them.
module ps2_key_filter
    import ps2_lcd_pkg::*;
(
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic [7:0] ps2_code,
    input  logic       ps2_code_ready,
    input  logic       ps2_make_code,
    input  logic       hold,
    output logic       key_valid,
    output key_class_t key_class,
    output logic [7:0] key_code,
    output logic       key_dropped
);

    logic ready_q;
    logic make_edge;

    assign make_edge = ps2_code_ready & ~ready_q & ps2_make_code;
    assign key_valid = make_edge & ~hold;
    assign key_code  = ps2_code;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            key_dropped <= 1'b0;
        end else begin
            ready_q     <= ps2_code_ready;
            key_dropped <= make_edge & hold;
        end
    end

    always_comb begin
        key_class = K_PRINT;
        case (ps2_code)
            KEY_LSHIFT: key_class = K_SHIFT_L;
            KEY_RSHIFT: key_class = K_SHIFT_R;
            KEY_BKSP:   key_class = K_BKSP;
            KEY_ENTER:  key_class = K_ENTER;
            default:    key_class = K_PRINT;
        endcase
    end

endmodule

// File: rtl/ps2_lcd_line_editor.sv
// Keyboard line editor: buffers make-codes into one line, then writes the line
// through the external translation ROM onto alternating LCD lines.
module ps2_lcd_line_editor
    import ps2_lcd_pkg::*;
#(
    parameter int LINE_LEN  = 16,
    parameter int NUM_LINES = 2,
    localparam int FW = $clog2(LINE_LEN + 1),
    localparam int MW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
)(
    input  logic          CLOCK_50_I,
    input  logic          resetn,
    input  logic [7:0]    ps2_code,
    input  logic          ps2_code_ready,
    input  logic          ps2_make_code,
    output logic [8:0]    rom_address,
    input  logic [7:0]    rom_q,
    output logic          lcd_start,
    output logic [8:0]    lcd_instruction,
    input  logic          lcd_done,
    output logic [FW-1:0] fill_count,
    output logic [MW-1:0] match_count,
    output logic          match_valid,
    output logic          busy,
    output logic          key_dropped,
    output logic [3:0]    dbg_state
);

    localparam int IW = MW;
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_LEN - 1);

    state_t state, state_nxt;

    logic [7:0]          buf_code [LINE_LEN];
    logic [LINE_LEN-1:0] buf_caps;
    logic [7:0]          eff_code [LINE_LEN];
    logic [LINE_LEN-1:0] eff_caps;

    logic          caps;
    logic          line_sel;
    logic [1:0]    init_idx;
    logic [IW-1:0] idx;
    logic          start_d;
    logic          line_full;
    logic          flushing;
    logic          done_ok;
    logic [MW-1:0] match_calc;
    logic [IW-1:0] wr_ptr;

    logic       issue;
    logic [8:0] issue_word;
    logic       init_adv;
    logic       idx_adv;
    logic       flush_end;

    logic       key_valid;
    key_class_t key_class;
    logic [7:0] key_code;

    assign line_full = (fill_count == FW'(LINE_LEN));
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign wr_ptr    = fill_count[IW-1:0];
    assign flushing  = state inside {S_SET_LINE, S_SET_LINE_WAIT, S_ROM_WAIT,
                                     S_ISSUE_CHAR, S_CHAR_WAIT, S_FLUSH_DONE};

    // LCD handshake: lcd_start is a one-cycle strobe with lcd_instruction valid
    // in the same cycle; lcd_done is honoured only once the strobe cycle and the
    // cycle after it have passed, and the next strobe follows the accepted done.
    assign done_ok = lcd_done & ~lcd_start & ~start_d;

    ps2_key_filter u_key_filter (
        .CLOCK_50_I     (CLOCK_50_I),
        .resetn         (resetn),
        .ps2_code       (ps2_code),
        .ps2_code_ready (ps2_code_ready),
        .ps2_make_code  (ps2_make_code),
        .hold           (busy | line_full),
        .key_valid      (key_valid),
        .key_class      (key_class),
        .key_code       (key_code),
        .key_dropped    (key_dropped)
    );

    // Positions past the fill point read as unshifted spaces
    always_comb begin
        for (int i = 0; i < LINE_LEN; i++) begin
            if (FW'(i) < fill_count) begin
                eff_code[i] = buf_code[i];
                eff_caps[i] = buf_caps[i];
            end else begin
                eff_code[i] = KEY_SPACE;
                eff_caps[i] = 1'b0;
            end
        end
    end

    always_comb begin
        match_calc = '0;
        for (int i = 1; i < LINE_LEN; i++) begin
            if (eff_code[i] == eff_code[0]) match_calc = match_calc + MW'(1);
        end
    end

    assign rom_address = flushing ? {eff_caps[idx], eff_code[idx]} : {caps, ps2_code};

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) state <= S_INIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_word = 9'h000;
        init_adv   = 1'b0;
        idx_adv    = 1'b0;
        flush_end  = 1'b0;
        case (state)
            S_INIT: begin
                issue      = 1'b1;
                issue_word = init_cmd(init_idx);
                state_nxt  = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (done_ok) begin
                    init_adv  = 1'b1;
                    state_nxt = (init_idx == 2'd3) ? S_IDLE : S_INIT;
                end
            end
            S_IDLE: begin
                if (line_full ||
                    (key_valid && key_class == K_ENTER && fill_count != '0))
                    state_nxt = S_SET_LINE;
            end
            S_SET_LINE: begin
                issue      = 1'b1;
                issue_word = line_instr(line_sel);
                state_nxt  = S_SET_LINE_WAIT;
            end
            S_SET_LINE_WAIT: begin
                if (done_ok) state_nxt = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                state_nxt = S_ISSUE_CHAR;
            end
            S_ISSUE_CHAR: begin
                issue      = 1'b1;
                issue_word = {1'b1, rom_q};
                state_nxt  = S_CHAR_WAIT;
            end
            S_CHAR_WAIT: begin
                if (done_ok) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_FLUSH_DONE;
                    end else begin
                        idx_adv   = 1'b1;
                        state_nxt = S_ROM_WAIT;
                    end
                end
            end
            S_FLUSH_DONE: begin
                flush_end = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            lcd_start       <= 1'b0;
            lcd_instruction <= 9'h000;
            start_d         <= 1'b0;
            init_idx        <= 2'd0;
            idx             <= '0;
            line_sel        <= 1'b0;
            caps            <= 1'b0;
            fill_count      <= '0;
            match_count     <= '0;
            match_valid     <= 1'b0;
        end else begin
            lcd_start <= issue;
            start_d   <= lcd_start;
            if (issue) lcd_instruction <= issue_word;
            if (init_adv) init_idx <= init_idx + 2'd1;

            if (idx_adv)        idx <= idx + IW'(1);
            else if (flush_end) idx <= '0;

            if (flush_end) begin
                line_sel    <= (NUM_LINES == 2) ? ~line_sel : 1'b0;
                fill_count  <= '0;
                match_count <= match_calc;
                match_valid <= 1'b1;
            end else if (key_valid) begin
                case (key_class)
                    K_SHIFT_L: caps <= 1'b1;
                    K_SHIFT_R: caps <= 1'b0;
                    K_BKSP: begin
                        if (fill_count != '0) fill_count <= fill_count - FW'(1);
                    end
                    K_PRINT: begin
                        fill_count  <= fill_count + FW'(1);
                        match_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The line store needs no reset: only positions below fill_count are read.
    always_ff @(posedge CLOCK_50_I) begin
        if (key_valid && key_class == K_PRINT) begin
            buf_code[wr_ptr] <= key_code;
            buf_caps[wr_ptr] <= caps;
        end
    end

endmodule

// File: tb/tb_ps2_lcd_line_editor.sv
// Directed bench for the line editor: LCD and ROM models, an instruction
// scoreboard fed from hand-computed expectations, and one summary line.
module tb_ps2_lcd_line_editor;

    localparam int LINE_LEN  = 4;
    localparam int NUM_LINES = 2;
    localparam int FW = $clog2(LINE_LEN + 1);
    localparam int MW = $clog2(LINE_LEN);

    logic          CLOCK_50_I = 1'b0;
    logic          resetn;
    logic [7:0]    ps2_code;
    logic          ps2_code_ready;
    logic          ps2_make_code;
    logic [8:0]    rom_address;
    logic [7:0]    rom_q;
    logic          lcd_start;
    logic [8:0]    lcd_instruction;
    logic          lcd_done;
    logic [FW-1:0] fill_count;
    logic [MW-1:0] match_count;
    logic          match_valid;
    logic          busy;
    logic          key_dropped;
    logic [3:0]    dbg_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_addr_q[$];
    logic       start_seen;
    int         lcd_cnt;

    ps2_lcd_line_editor #(.LINE_LEN(LINE_LEN), .NUM_LINES(NUM_LINES)) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .resetn          (resetn),
        .ps2_code        (ps2_code),
        .ps2_code_ready  (ps2_code_ready),
        .ps2_make_code   (ps2_make_code),
        .rom_address     (rom_address),
        .rom_q           (rom_q),
        .lcd_start       (lcd_start),
        .lcd_instruction (lcd_instruction),
        .lcd_done        (lcd_done),
        .fill_count      (fill_count),
        .match_count     (match_count),
        .match_valid     (match_valid),
        .busy            (busy),
        .key_dropped     (key_dropped),
        .dbg_state       (dbg_state)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        return a[7:0] ^ (a[8] ? 8'hA5 : 8'h00);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50_I) rom_q <= rom_fn(rom_address);

    always @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            lcd_cnt  <= 0;
            lcd_done <= 1'b0;
        end else begin
            lcd_done <= 1'b0;
            if (lcd_start) lcd_cnt <= $urandom_range(5, 2);
            else if (lcd_cnt == 1) begin
                lcd_done <= 1'b1;
                lcd_cnt  <= 0;
            end else if (lcd_cnt > 1) lcd_cnt <= lcd_cnt - 1;
        end
    end

    // Scoreboard: every strobe is matched against the expected instruction queue
    always @(negedge CLOCK_50_I) begin
        logic [8:0] e;
        if (resetn && lcd_start) begin
            check_val("start_width", 32'(start_seen), 0);
            if (exp_q.size() == 0) check_val("lcd_unexpected_queued", 32'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                check_val("lcd_instr", 32'(lcd_instruction), 32'(e));
                if (lcd_instruction[8]) begin
                    if (exp_addr_q.size() == 0)
                        check_val("rom_addr_unexpected_queued", 32'(exp_addr_q.size()), 1);
                    else begin
                        e = exp_addr_q.pop_front();
                        check_val("rom_addr", 32'(rom_address), 32'(e));
                    end
                end
            end
        end
        start_seen <= resetn & lcd_start;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50_I);
    endtask

    task automatic send_key(input logic [7:0] code, input logic make);
        @(negedge CLOCK_50_I);
        ps2_code       = code;
        ps2_make_code  = make;
        ps2_code_ready = 1'b1;
        @(negedge CLOCK_50_I);
        ps2_code_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        check_val(tag, 32'(busy), 0);
    endtask

    task automatic wait_state(input logic [3:0] st, input string tag);
        int n = 0;
        while (dbg_state !== st && n < 3000) begin
            @(negedge CLOCK_50_I);
            n++;
        end
        check_val(tag, 32'(dbg_state), 32'(st));
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic push_char(input logic [8:0] a);
        exp_q.push_back({1'b1, rom_fn(a)});
        exp_addr_q.push_back(a);
    endtask

    task automatic expect_flush(input logic [8:0] line, input logic [8:0] a0,
                                input logic [8:0] a1, input logic [8:0] a2,
                                input logic [8:0] a3);
        exp_q.push_back(line);
        push_char(a0);
        push_char(a1);
        push_char(a2);
        push_char(a3);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_lcd_start"},   32'(lcd_start), 0);
        check_val({pfx, "_lcd_instr"},   32'(lcd_instruction), 0);
        check_val({pfx, "_fill"},        32'(fill_count), 0);
        check_val({pfx, "_match"},       32'(match_count), 0);
        check_val({pfx, "_match_valid"}, 32'(match_valid), 0);
        check_val({pfx, "_busy"},        32'(busy), 1);
        check_val({pfx, "_key_dropped"}, 32'(key_dropped), 0);
        check_val({pfx, "_rom_addr"},    32'(rom_address), 0);
    endtask

    task automatic check_flush_result(input string pfx, input int mc);
        check_val({pfx, "_match"},       32'(match_count), 32'(mc));
        check_val({pfx, "_match_valid"}, 32'(match_valid), 1);
        check_val({pfx, "_fill"},        32'(fill_count), 0);
        check_val({pfx, "_drained"},     32'(exp_q.size()), 0);
    endtask

    initial begin
        resetn         = 1'b0;
        ps2_code       = 8'h00;
        ps2_code_ready = 1'b0;
        ps2_make_code  = 1'b0;

        // Reset and LCD initialisation
        tick(3);
        check_reset_vals("rst");
        push_init();
        resetn = 1'b1;
        tick(1);
        check_val("init_busy", 32'(busy), 1);
        wait_idle("init_done");
        tick(20);
        check_val("init_drained", 32'(exp_q.size()), 0);
        check_val("idle_busy", 32'(busy), 0);

        // Auto flush of a full line onto LCD line 0
        expect_flush(9'h080, 9'h01C, 9'h032, 9'h01C, 9'h01C);
        send_key(8'h1C, 1'b1);
        check_val("fill_1", 32'(fill_count), 1);
        send_key(8'h1C, 1'b0);
        check_val("break_ignored", 32'(fill_count), 1);
        send_key(8'h32, 1'b1);
        check_val("fill_2", 32'(fill_count), 2);
        send_key(8'h1C, 1'b1);
        check_val("fill_3", 32'(fill_count), 3);
        send_key(8'h1C, 1'b1);
        check_val("fill_4", 32'(fill_count), 4);
        check_val("busy_before_flush", 32'(busy), 0);
        tick(1);
        check_val("busy_flush_start", 32'(busy), 1);
        wait_idle("flush1_done");
        check_flush_result("flush1", 2);

        // Shift state per character, Enter pads, second LCD line
        expect_flush(9'h0C0, 9'h11C, 9'h01C, 9'h029, 9'h029);
        send_key(8'h12, 1'b1);
        check_val("shift_not_stored", 32'(fill_count), 0);
        check_val("caps_addr", 32'(rom_address), 32'h112);
        send_key(8'h1C, 1'b1);
        check_val("shift_fill_1", 32'(fill_count), 1);
        check_val("match_valid_cleared", 32'(match_valid), 0);
        send_key(8'h59, 1'b1);
        check_val("uncaps_addr", 32'(rom_address), 32'h059);
        send_key(8'h1C, 1'b1);
        check_val("shift_fill_2", 32'(fill_count), 2);
        send_key(8'h5A, 1'b1);
        check_val("enter_busy", 32'(busy), 1);
        wait_idle("flush2_done");
        check_flush_result("flush2", 1);

        // Backspace and Enter on an empty line
        send_key(8'h66, 1'b1);
        check_val("bksp_empty", 32'(fill_count), 0);
        send_key(8'h1C, 1'b1);
        check_val("bksp_fill_1", 32'(fill_count), 1);
        send_key(8'h66, 1'b1);
        check_val("bksp_fill_0", 32'(fill_count), 0);
        send_key(8'h5A, 1'b1);
        check_val("enter_empty_busy", 32'(busy), 0);
        tick(20);
        check_val("enter_empty_idle", 32'(busy), 0);
        check_val("enter_empty_drained", 32'(exp_q.size()), 0);
        check_val("bksp_match_valid", 32'(match_valid), 0);

        // Key arriving during CHAR_WAIT is dropped; line wraps back to 0x080
        expect_flush(9'h080, 9'h02B, 9'h029, 9'h029, 9'h029);
        send_key(8'h2B, 1'b1);
        send_key(8'h5A, 1'b1);
        wait_state(4'd7, "reach_char_wait");
        ps2_code       = 8'h1C;
        ps2_make_code  = 1'b1;
        ps2_code_ready = 1'b1;
        tick(1);
        check_val("drop_pulse_hi", 32'(key_dropped), 1);
        ps2_code_ready = 1'b0;
        tick(1);
        check_val("drop_pulse_lo", 32'(key_dropped), 0);
        wait_idle("flush3_done");
        check_flush_result("flush3", 0);

        // Reset in the middle of a flush on line 1
        expect_flush(9'h0C0, 9'h03A, 9'h029, 9'h029, 9'h029);
        send_key(8'h3A, 1'b1);
        send_key(8'h5A, 1'b1);
        wait_state(4'd7, "reach_char_wait_rst");
        tick(1);
        check_val("pre_rst_remaining", 32'(exp_q.size()), 3);
        ps2_code      = 8'h00;
        ps2_make_code = 1'b0;
        resetn        = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        push_init();
        tick(2);
        resetn = 1'b1;
        wait_idle("reinit_done");
        tick(10);
        check_val("reinit_drained", 32'(exp_q.size()), 0);
        check_val("reinit_fill", 32'(fill_count), 0);
        check_val("reinit_match_valid", 32'(match_valid), 0);

        // line_sel restarts at 0 after reset
        expect_flush(9'h080, 9'h01C, 9'h029, 9'h029, 9'h029);
        send_key(8'h1C, 1'b1);
        send_key(8'h5A, 1'b1);
        wait_idle("flush4_done");
        check_flush_result("flush4", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_lcd_line_editor.md
# ps2_lcd_line_editor

Parametrised keyboard-to-LCD line editor sitting between `PS2_controller` and `LCD_controller`, replacing the fixed 16-character shift-register front end. It buffers make-codes into a `LINE_LEN` line with per-character shift state, backspace and enter support, then writes the whole line through the external PS2-to-LCD translation ROM onto successive LCD lines. It also reports how many characters in the flushed line repeat the line's first character.

## Interface
- `LINE_LEN`, 16, characters per line; legal range 1..40.
- `NUM_LINES`, 2, LCD lines used round-robin; legal values 1 or 2.
- `CLOCK_50_I` in 1: 50 MHz clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_code` in 8: scan code from `PS2_controller`.
- `ps2_code_ready` in 1: level; a rising edge marks a new code.
- `ps2_make_code` in 1: 1 = make, 0 = break.
- `rom_address` out 9: `{caps, code}` to the translation ROM. The ROM has 1-cycle registered latency.
- `rom_q` in 8: LCD character code from the ROM.
- `lcd_start` out 1: one-cycle command strobe.
- `lcd_instruction` out 9: `{cmd/data, byte}` to the LCD controller.
- `lcd_done` in 1: LCD controller completion.
- `fill_count` out `$clog2(LINE_LEN+1)`: characters currently buffered.
- `match_count` out `$clog2(LINE_LEN)`: repeats of position 0 in the last flushed line.
- `match_valid` out 1: `match_count` is meaningful.
- `busy` out 1: initialising or writing the LCD.
- `key_dropped` out 1: one-cycle pulse when a make-code arrives while `busy`.

## Operation
- **Key event:** `ps2_code_ready` rising edge (internal registered copy) with `ps2_make_code`=1. Break codes are ignored.
- **Shift keys:** 0x12 sets `caps`=1; 0x59 sets `caps`=0. Neither is stored.
- **Backspace (0x66):** decrements `fill_count` if it is nonzero; ignored on an empty line.
- **Enter (0x5A):** flushes a non-empty line. Unfilled positions are padded with 0x29 (space), caps 0. Ignored on an empty line.
- **Any other code:** stored at index `fill_count` with the current `caps`, then `fill_count`+1.
  - If the line reaches `LINE_LEN`, the flush starts on the next cycle.
  - Clears `match_valid`.
- **Events while `busy`:** dropped; `key_dropped` pulses.
- **States:** INIT, INIT_WAIT, IDLE, SET_LINE, SET_LINE_WAIT, ROM_WAIT, ISSUE_CHAR, CHAR_WAIT, FLUSH_DONE.
- **INIT/INIT_WAIT:** issue 0x038, 0x00C, 0x001, 0x006 in order, each waiting for `lcd_done`, then go to IDLE.
- **Flush:**
  - SET_LINE issues `{2'b01, line_sel, 6'h00}`, then SET_LINE_WAIT.
  - For each index i = 0..`LINE_LEN`-1: ROM_WAIT (the ROM samples `rom_address`), ISSUE_CHAR (issues `{1'b1, rom_q}`), CHAR_WAIT.
  - After the last character, FLUSH_DONE:
    - `line_sel` advances modulo `NUM_LINES`.
    - `fill_count`=0.
    - `match_count` = number of positions 1..`LINE_LEN`-1 whose code equals position 0's code. Caps are ignored; padding counts if position 0 is a space.
    - `match_valid`=1; `caps` is retained.
- **`rom_address`:** combinational. In flush states it is `{caps[i], code[i]}`; otherwise `{caps, ps2_code}`.
- **Reset mid-operation:** aborts everything and restarts INIT. No partial LCD state is assumed.

## Timing
- **Reset values:** `lcd_start` 0, `lcd_instruction` 0, `fill_count` 0, `match_count` 0, `match_valid` 0, `busy` 1, `key_dropped` 0, `rom_address` 0. Internally `line_sel` 0 and `caps` 0.
- **LCD handshake:**
  - `lcd_start` is high exactly one cycle, with `lcd_instruction` valid in the same cycle.
  - `lcd_done` is ignored while `lcd_start`=1 and in the cycle after it.
  - The next instruction is issued no earlier than the cycle after `lcd_done`=1 is sampled.
- **`busy`:** 1 from reset until IDLE. Rises the cycle after a flush is triggered and falls on entry to IDLE after FLUSH_DONE.
- **Key acceptance:** an accepted key updates `fill_count` 1 cycle after the edge; the flush begins (`busy`=1) on the following cycle.
- **Per-character cost:** 2 cycles plus the LCD controller delay.
- **Simultaneous key edge and FLUSH_DONE:** the key is dropped.

## Structure
- **Package `ps2_lcd_pkg`:**
  - state enum;
  - key constants `KEY_LSHIFT` 0x12, `KEY_RSHIFT` 0x59, `KEY_BKSP` 0x66, `KEY_ENTER` 0x5A, `KEY_SPACE` 0x29;
  - LCD init sequence constants;
  - line-address helper function.
- **Sub-module `ps2_key_filter`:** edge detect, make filtering, classification into {shift_l, shift_r, bksp, enter, printable}, and `key_dropped` generation.
- **Buffer:** `LINE_LEN`x9 register array (code plus caps); no RAM.

## Test plan
- **Reset then idle:** `busy` stays 1 through four instructions (0x038, 0x00C, 0x001, 0x006) -> then 0, with no further `lcd_start`.
- **`LINE_LEN`=4, keys 0x1C,0x32,0x1C,0x1C:**
  - auto-flush issues 0x080;
  - then 4 data instructions `{1, rom_q}` with `rom_address` 0x01C,0x032,0x01C,0x01C;
  - result `match_count`=2, `match_valid`=1, `fill_count`=0.
- **Shift case:** press 0x12, 0x1C, 0x59, 0x1C, Enter (`LINE_LEN`=4) -> `rom_address` sequence 0x11C, 0x01C, 0x029, 0x029; next flush uses line instruction 0x0C0.
- **Backspace:** 0x66 on empty -> `fill_count` stays 0; 0x1C, 0x66 -> `fill_count` 1 then 0; Enter on empty -> no LCD activity.
- **Busy drop:** key edge during CHAR_WAIT -> `key_dropped` 1-cycle pulse, buffer unchanged after flush.
- **Wrap and reset:** with `NUM_LINES`=2, three flushes -> line instructions 0x080, 0x0C0, 0x080. Assert `resetn`=0 mid-flush -> all outputs at reset values, INIT restarts.
